// File: rtl/alu_pkg.sv
// Shared types for the ALU with iterative M-extension: op codes, ALUOp selectors, FSM states.
// Includes small classification helpers used by the datapath.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_XOR    = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SUB    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_SLT    = 5'b01000,
        OP_SLTU   = 5'b01001,
        OP_MUL    = 5'b01010,
        OP_MULH   = 5'b01011,
        OP_MULHSU = 5'b01100,
        OP_MULHU  = 5'b01101,
        OP_DIV    = 5'b01110,
        OP_DIVU   = 5'b01111,
        OP_REM    = 5'b10000,
        OP_REMU   = 5'b10001
    } alu_op_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_mul(input alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input alu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_mop(input alu_op_t op);
        return is_mul(op) || is_div(op);
    endfunction

    function automatic logic a_is_signed(input alu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_is_signed(input alu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of {instr[25], instr[30], funct3} and ALUOp into an alu_op_t.
// Undefined encodings fall back to ADD.
module alu_decode
    import alu_pkg::*;
#(
    parameter int MEXT = 1
) (
    input  logic [4:0] instr,
    input  logic [1:0] ALUOp,
    output alu_op_t    op
);

    always_comb begin
        op = OP_ADD;
        case (ALUOp)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            default: begin
                if (!instr[4]) begin
                    case (instr[2:0])
                        3'b000:  op = (ALUOp == ALUOP_RTYPE && instr[3]) ? OP_SUB : OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = instr[3] ? OP_SRA : OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (ALUOp == ALUOP_RTYPE && MEXT != 0) begin
                    case (instr[2:0])
                        3'b000:  op = OP_MUL;
                        3'b001:  op = OP_MULH;
                        3'b010:  op = OP_MULHSU;
                        3'b011:  op = OP_MULHU;
                        3'b100:  op = OP_DIV;
                        3'b101:  op = OP_DIVU;
                        3'b110:  op = OP_REM;
                        default: op = OP_REMU;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_mext.sv
// Single-issue ALU: base ops and divide fast paths answer in one cycle, MUL*/DIV*/REM*
// iterate one bit per cycle on magnitudes, with sign fix-up folded into the final step.
module alu_mext
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MEXT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      instr,
    input  logic [1:0]      ALUOp,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_op_t op;

    alu_decode #(.MEXT(MEXT)) u_decode (
        .instr (instr),
        .ALUOp (ALUOp),
        .op    (op)
    );

    state_t          state, state_nxt;
    logic [SH_W-1:0] cnt;
    alu_op_t         mop;
    logic            neg;
    logic [XLEN-1:0] acc, lo, opnd;

    logic            accept, start_iter, div_fast, a_neg, b_neg;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] mag_a, mag_b, quick_res, step_acc, step_lo, final_res;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod, prod_fin;

    assign accept = in_valid && in_ready;
    assign shamt  = op_b[SH_W-1:0];
    assign a_neg  = a_is_signed(op) && op_a[XLEN-1];
    assign b_neg  = b_is_signed(op) && op_b[XLEN-1];
    assign mag_a  = a_neg ? -op_a : op_a;
    assign mag_b  = b_neg ? -op_b : op_b;

    // Divide by zero and MIN/-1 never enter the iterator; their answers are fixed.
    assign div_fast = is_div(op) &&
                      ((op_b == '0) || (b_is_signed(op) && op_a == MOST_NEG && op_b == '1));
    assign start_iter = accept && is_mop(op) && !div_fast;

    always_comb begin
        quick_res = op_a + op_b;
        case (op)
            OP_SUB:           quick_res = op_a - op_b;
            OP_AND:           quick_res = op_a & op_b;
            OP_OR:            quick_res = op_a | op_b;
            OP_XOR:           quick_res = op_a ^ op_b;
            OP_SLL:           quick_res = op_a << shamt;
            OP_SRL:           quick_res = op_a >> shamt;
            OP_SRA:           quick_res = XLEN'($signed(op_a) >>> shamt);
            OP_SLT:           quick_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:          quick_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_DIV, OP_DIVU:  quick_res = (op_b == '0) ? '1 : op_a;
            OP_REM, OP_REMU:  quick_res = (op_b == '0) ? op_a : '0;
            default:          ;
        endcase
    end

    // acc/lo hold {high, low} product halves for MUL*, {remainder, dividend->quotient} for DIV*.
    always_comb begin
        mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (is_mul(mop)) begin
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_acc = div_diff[XLEN-1:0];
            step_lo  = {lo[XLEN-2:0], 1'b1};
        end else begin
            step_acc = div_sh[XLEN-1:0];
            step_lo  = {lo[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod     = {step_acc, step_lo};
        prod_fin = neg ? -prod : prod;
        case (mop)
            OP_MUL:                       final_res = prod_fin[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fin[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:              final_res = neg ? -step_acc : step_acc;
            default:                      final_res = neg ? -step_lo : step_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_iter) state_nxt = ITER;
            ITER:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ITER);
        in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            lo        <= '0;
            opnd      <= '0;
            mop       <= OP_ADD;
            neg       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (start_iter) begin
                    cnt  <= SH_W'(XLEN - 1);
                    mop  <= op;
                    neg  <= is_rem(op) ? a_neg : (a_neg ^ b_neg);
                    acc  <= '0;
                    lo   <= is_mul(op) ? mag_b : mag_a;
                    opnd <= is_mul(op) ? mag_a : mag_b;
                end else begin
                    result    <= quick_res;
                    out_valid <= 1'b1;
                end
            end else if (state == ITER) begin
                acc <= step_acc;
                lo  <= step_lo;
                if (cnt == '0) begin
                    result    <= final_res;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt - SH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mext.sv
// Scoreboard bench for alu_mext: requests push expected results from a plain-arithmetic model;
// a monitor checks every response, its latency, busy, and the hold behaviour under backpressure.
module tb_alu_mext;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  instr;
    logic [1:0]  ALUOp;
    logic [31:0] op_a, op_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    alu_mext #(.XLEN(32), .MEXT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .ALUOp     (ALUOp),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   iter_acc = -1000;
    bit   rdy_force_en  = 1'b0;
    bit   rdy_force_val = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] aop, input logic [4:0] ins,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output int lat);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [4:0]  sh;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        sh  = b[4:0];
        lat = 1;
        r   = a + b;
        if (aop == 2'b01) begin
            r = a - b;
        end else if (aop[1] && !ins[4]) begin
            case (ins[2:0])
                3'd0: r = (aop == 2'b10 && ins[3]) ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = ins[3] ? 32'(sa >>> sh) : a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (aop == 2'b10 && ins[4]) begin
            case (ins[2:0])
                3'd0: begin p = ua * ub; r = p[31:0];  lat = 33; end
                3'd1: begin p = sa * sb; r = p[63:32]; lat = 33; end
                3'd2: begin p = sa * ub; r = p[63:32]; lat = 33; end
                3'd3: begin p = ua * ub; r = p[63:32]; lat = 33; end
                3'd4: begin
                    if (b == 32'd0) r = 32'hFFFF_FFFF;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                    else begin r = 32'(sa / sb); lat = 33; end
                end
                3'd5: begin
                    if (b == 32'd0) r = 32'hFFFF_FFFF;
                    else begin r = 32'(ua / ub); lat = 33; end
                end
                3'd6: begin
                    if (b == 32'd0) r = a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                    else begin r = 32'(sa % sb); lat = 33; end
                end
                default: begin
                    if (b == 32'd0) r = a;
                    else begin r = 32'(ua % ub); lat = 33; end
                end
            endcase
        end
        return r;
    endfunction

    // Issue one request, holding it until accepted, and record what the response must be.
    task automatic send(input logic [1:0] aop, input logic [4:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        output int waited);
        exp_t e;
        @(posedge clk); #1;
        ALUOp = aop; instr = ins; op_a = a; op_b = b; in_valid = 1'b1;
        waited = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                waited = t;
                break;
            end
        end
        if (waited < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 300 cycles, required 1");
        end else begin
            e.res = exp; e.lat = lat; e.acc = cyc;
            sbq.push_back(e);
            if (lat > 1) iter_acc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [1:0] aop, input logic [4:0] ins,
                              input logic [31:0] a, input logic [31:0] b);
        int          lat, w;
        logic [31:0] exp;
        exp = model(aop, ins, a, b, lat);
        send(aop, ins, a, b, exp, lat, w);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses still outstanding, required 0", sbq.size());
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'($urandom_range(0, 15));
            2: return 32'd0;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0000;
            default: return -32'($urandom_range(1, 15));
        endcase
    endfunction

    // Backpressure source: random unless a directed test takes control.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_force_en ? rdy_force_val : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                continue;
            end
            check("busy", 32'(busy), 32'((cyc >= iter_acc + 1) && (cyc <= iter_acc + 32)));
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_response: got result %h with nothing outstanding", result);
                end else begin
                    if (!seen) begin
                        check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                        seen = 1'b1;
                    end
                    check("result", result, sbq[0].res);
                    if (!out_ready) begin
                        check("in_ready_hold", 32'(in_ready), 32'd0);
                    end else begin
                        sbq.delete(0);
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, n;
        logic [1:0]  aop;
        logic [4:0]  ins;
        rst = 1'b1; in_valid = 1'b0; instr = '0; ALUOp = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send(2'b10, 5'b00000, 32'd5, 32'd7, 32'd12, 1, w);
        send(2'b11, 5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, w);
        send(2'b10, 5'b10011, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 33, w);
        send(2'b10, 5'b10000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, w);
        send(2'b10, 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, w);
        send(2'b10, 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, w);
        send(2'b10, 5'b10101, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, w);
        send(2'b10, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, w);
        send(2'b10, 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, w);
        send(2'b10, 5'b10111, 32'd77, 32'd0, 32'd77, 1, w);

        // Backpressure hold, then a same-cycle handshake plus new request.
        wait_drain();
        rdy_force_en = 1'b1; rdy_force_val = 1'b0;
        send(2'b00, 5'b00000, 32'd3, 32'd4, 32'd7, 1, w);
        repeat (5) @(negedge clk);
        rdy_force_val = 1'b1;
        send(2'b01, 5'b00000, 32'd10, 32'd3, 32'd7, 1, w);
        check("b2b_accept_wait", 32'(w), 32'd0);
        @(negedge clk);
        rdy_force_en = 1'b0;

        // Reset in the middle of a divide must abort it silently.
        wait_drain();
        send(2'b10, 5'b10100, 32'd100, 32'd7, 32'd14, 33, w);
        n = iter_acc;
        do begin
            @(posedge clk); #1;
        end while (cyc < n + 10);
        rst = 1'b1;
        sbq.delete();
        iter_acc = -1000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        send(2'b00, 5'b00000, 32'd1, 32'd1, 32'd2, 1, w);

        for (int i = 0; i < 150; i++) begin
            aop = 2'($urandom_range(0, 3));
            ins = 5'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                aop = 2'b10;
                ins[4] = 1'b1;
            end
            send_model(aop, ins, pick_operand(), pick_operand());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
